pipe_stage_reg: RTL
===================

# pipe_stage_reg

Generic, parametrised pipeline stage register that replaces the fixed IF/ID latch and serves every stage boundary of the pipelined core. It carries instruction, PC and one auxiliary payload word across a valid/ready handshake, squashes on flush and decodes the source-register selects from the latched instruction. An optional skid entry breaks the combinational ready path between stages.

## Interface
Parameters:
- AUX_W, 32, width of the auxiliary payload (JAL target, branch target, ...).
- FLUSH_INSTR, 32'h0000_0000, instruction word loaded into the main slot on flush (NOP).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held entries; input offered this cycle is discarded.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept an entry.
- in_instr  in  32  instruction word (word_t).
- in_pc  in  32  instruction address (word_t).
- in_aux  in  AUX_W  auxiliary payload.
- out_valid  out  1  main slot holds a live entry.
- out_ready  in  1  downstream consumes the entry.
- out_instr  out  32  main-slot instruction.
- out_pc  out  32  main-slot PC.
- out_aux  out  AUX_W  main-slot aux payload.
- out_rsel1  out  5  out_instr[25:21] (rs).
- out_rsel2  out  5  out_instr[20:16] (rt).
- occupancy  out  2  number of live entries (0..2).

## Operation
- Accept = in_valid && in_ready. Consume = out_valid && out_ready.
- Two slots: main M (drives out_*) and skid S (present only with skid enabled).
- Priority per edge: RST > flush > normal transfer.
- RST: M and S invalid; all payload registers, including instr, cleared to 0.
- flush: M and S invalid; M.instr <= FLUSH_INSTR; M.pc and M.aux hold. Neither accept nor consume takes effect.
- Normal:
  - M empty: accept loads M.
  - M full and consume: accept loads M; otherwise M goes invalid.
  - M full, no consume, accept: entry loads S.
  - S full and consume: M <= S, S invalid. No accept is possible while S is full.
- in_ready = !S.valid, a registered-state function with no path from out_ready.
- out_rsel1/2 are combinational slices of out_instr. Under FLUSH_INSTR = 0 they read 0.
- occupancy = M.valid + S.valid.
- Payload registers do not load when no accept occurs (hold); saves power.

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N (one cycle).
- Reset values: out_valid 0, out_instr/out_pc/out_aux 0, out_rsel1/2 0, occupancy 0, in_ready 1.
- Throughput: one entry per cycle when out_ready is held high.
- Back-pressure: with out_ready low and a full M, exactly one further entry is absorbed into S. in_ready drops the following cycle.
- Order is strictly FIFO: M is always older than S.
- Flush asserted together with accept or consume: flush wins, and the upstream entry is lost by design.
- Flush for several cycles: the stage stays empty and in_ready stays 1.
- RST in the middle of a stall: all state is cleared at that edge, and the stage is usable the next cycle.

## Configuration
- PIPE_SKID_EN defined: two slots as above; in_ready is registered and independent of out_ready.
- Undefined: no S slot.
  - in_ready = out_ready || !M.valid (combinational).
  - occupancy is at most 1.
  - All other behaviour is identical.

## Structure
- Shared cpu_types_pkg:
  - word_t and regbits_t.
  - New constants RS_MSB = 25, RS_LSB = 21, RT_MSB = 20, RT_LSB = 16.
  - NOP_INSTR = 32'h0 as the default for FLUSH_INSTR.
- Sub-module pipe_slot: one valid + payload register with load, clear and flush-load inputs, instantiated for M and (under PIPE_SKID_EN) S.
- Wrapper stage instances (IF/ID, ID/EX, ...) bind the named fields.

## Test plan
- RST, then offer instr 0x8C22_0004, pc 0x40, out_ready 1:
  - out_valid is 1 the next cycle.
  - out_rsel1 = 1, out_rsel2 = 2.
  - occupancy = 1.
- Stream 4 entries (pc 0x0/0x4/0x8/0xC) with out_ready held high: one entry out per cycle, in order, and in_ready is never 0.
- Skid enabled, out_ready 0, offer 3 entries:
  - First fills M and second fills S.
  - in_ready drops after the second; the third is held upstream.
  - Raising out_ready drains pc 0x0 then 0x4.
- Flush with M and S full and in_valid high:
  - Next cycle out_valid 0, out_instr 0x0000_0000, occupancy 0, in_ready 1.
  - The offered entry never appears.
- RST asserted during a stall: all outputs read the reset values listed in Timing after the edge. Then a single entry passes through with 1-cycle latency.
- Skid disabled: out_ready 0 with M full gives in_ready 0 in the same cycle; out_ready 1 gives in_ready 1 combinationally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared core types: machine word, register select and the instruction field
// positions used to decode rs/rt from a latched instruction.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   localparam int unsigned RS_MSB = 25;
   localparam int unsigned RS_LSB = 21;
   localparam int unsigned RT_MSB = 20;
   localparam int unsigned RT_LSB = 16;

   localparam word_t NOP_INSTR = 32'h0000_0000;

   function automatic regbits_t rs_of(input word_t instr);
      return instr[RS_MSB:RS_LSB];
   endfunction

   function automatic regbits_t rt_of(input word_t instr);
      return instr[RT_MSB:RT_LSB];
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus instr/pc/aux payload registers.
// Priority RST > flush-load > load > clear; payload holds unless loaded.
module pipe_slot
   import cpu_types_pkg::*;
#(
   parameter int unsigned AUX_W       = 32,
   parameter word_t       FLUSH_INSTR = NOP_INSTR
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic             i_flush_ld,
   input  word_t            i_instr,
   input  word_t            i_pc,
   input  logic [AUX_W-1:0] i_aux,
   output logic             o_valid,
   output word_t            o_instr,
   output word_t            o_pc,
   output logic [AUX_W-1:0] o_aux
);

   logic             r_valid;
   word_t            r_instr;
   word_t            r_pc;
   logic [AUX_W-1:0] r_aux;

   // Flush squashes the entry and plants the NOP; pc/aux are left as they were.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
         r_aux   <= '0;
      end else if (i_flush_ld) begin
         r_valid <= 1'b0;
         r_instr <= FLUSH_INSTR;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_aux   <= i_aux;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_aux   = r_aux;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush and rs/rt decode.
// Define PIPE_SKID_EN to add a skid slot that registers in_ready.
module pipe_stage_reg
   import cpu_types_pkg::*;
#(
   parameter int unsigned AUX_W       = 32,
   parameter word_t       FLUSH_INSTR = NOP_INSTR
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  word_t            in_instr,
   input  word_t            in_pc,
   input  logic [AUX_W-1:0] in_aux,
   output logic             out_valid,
   input  logic             out_ready,
   output word_t            out_instr,
   output word_t            out_pc,
   output logic [AUX_W-1:0] out_aux,
   output regbits_t         out_rsel1,
   output regbits_t         out_rsel2,
   output logic [1:0]       occupancy
);

   logic             w_acc;
   logic             w_cons;
   logic             w_m_load;
   logic             w_m_clear;
   logic             w_m_valid;
   word_t            w_ld_instr;
   word_t            w_ld_pc;
   logic [AUX_W-1:0] w_ld_aux;

`ifdef PIPE_SKID_EN
   logic             w_s_load;
   logic             w_s_clear;
   logic             w_s_valid;
   word_t            w_s_instr;
   word_t            w_s_pc;
   logic [AUX_W-1:0] w_s_aux;

   assign in_ready = !w_s_valid;

   // M refills from S when S is occupied, otherwise from the upstream port.
   always_comb begin
      w_acc      = in_valid && !w_s_valid && !flush;
      w_cons     = w_m_valid && out_ready && !flush;
      w_m_load   = w_s_valid ? w_cons : (w_acc && (!w_m_valid || w_cons));
      w_m_clear  = w_cons && !w_m_load;
      w_s_load   = w_acc && w_m_valid && !w_cons;
      w_s_clear  = w_s_valid && w_cons;
      w_ld_instr = w_s_valid ? w_s_instr : in_instr;
      w_ld_pc    = w_s_valid ? w_s_pc    : in_pc;
      w_ld_aux   = w_s_valid ? w_s_aux   : in_aux;
   end

   pipe_slot #(.AUX_W(AUX_W), .FLUSH_INSTR(FLUSH_INSTR)) u_s_slot (
      .CLK        (CLK),
      .RST        (RST),
      .i_load     (w_s_load),
      .i_clear    (w_s_clear || flush),
      .i_flush_ld (1'b0),
      .i_instr    (in_instr),
      .i_pc       (in_pc),
      .i_aux      (in_aux),
      .o_valid    (w_s_valid),
      .o_instr    (w_s_instr),
      .o_pc       (w_s_pc),
      .o_aux      (w_s_aux)
   );

   assign occupancy = 2'(w_m_valid) + 2'(w_s_valid);
`else
   assign in_ready = out_ready || !w_m_valid;

   always_comb begin
      w_acc      = in_valid && in_ready && !flush;
      w_cons     = w_m_valid && out_ready && !flush;
      w_m_load   = w_acc;
      w_m_clear  = w_cons && !w_acc;
      w_ld_instr = in_instr;
      w_ld_pc    = in_pc;
      w_ld_aux   = in_aux;
   end

   assign occupancy = {1'b0, w_m_valid};
`endif

   pipe_slot #(.AUX_W(AUX_W), .FLUSH_INSTR(FLUSH_INSTR)) u_m_slot (
      .CLK        (CLK),
      .RST        (RST),
      .i_load     (w_m_load),
      .i_clear    (w_m_clear),
      .i_flush_ld (flush),
      .i_instr    (w_ld_instr),
      .i_pc       (w_ld_pc),
      .i_aux      (w_ld_aux),
      .o_valid    (w_m_valid),
      .o_instr    (out_instr),
      .o_pc       (out_pc),
      .o_aux      (out_aux)
   );

   assign out_valid = w_m_valid;
   assign out_rsel1 = rs_of(out_instr);
   assign out_rsel2 = rt_of(out_instr);

endmodule
